// File: rtl/pipe_stage_reg_if.sv
// Valid/ready channel bundle for pipe_stage_reg: upstream (in_*) and downstream (out_*) sides.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 16
);
    // Upstream side
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;

    // Downstream side
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    // The stage itself
    modport slave (
        input  in_valid,
        input  in_ctrl,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_ctrl,
        output out_data,
        input  out_ready
    );

    // Surrounding pipeline / environment
    modport master (
        output in_valid,
        output in_ctrl,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_ctrl,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid
// buffer and synchronous flush that inserts a bubble (control forced to
// CTRL_RST, data to 0).
// Optional performance counters: define PIPE_STAGE_PERF_EN to enable
// stall_cnt / bubble_cnt; otherwise both outputs are tied to 0.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W   = 64,
    parameter int unsigned       CTRL_W   = 16,
    parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    pipe_stage_reg_if.slave     bus,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         bubble_cnt
);

    localparam int unsigned CNT_W = 32;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Safe entry used on reset, flush and whenever the main slot empties
    localparam entry_t ENTRY_RST = {CTRL_RST, {DATA_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e state_q;
    state_e state_d;
    entry_t main_q;
    entry_t main_d;
    entry_t skid_q;
    entry_t skid_d;
    entry_t in_entry;

    logic in_rdy;
    logic out_vld;
    logic in_fire;
    logic out_fire;

    assign in_entry = {bus.in_ctrl, bus.in_data};
    assign in_fire  = bus.in_valid & in_rdy;
    assign out_fire = out_vld & bus.out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides any handshake in the same cycle
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && !out_fire) begin
                        state_d = ST_TWO;
                    end else if (!in_fire && out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs decoded from the state register only (no out_ready -> in_ready path)
    always_comb begin
        in_rdy  = 1'b1;
        out_vld = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                in_rdy  = 1'b1;
                out_vld = 1'b0;
            end
            ST_ONE: begin
                in_rdy  = 1'b1;
                out_vld = 1'b1;
            end
            ST_TWO: begin
                in_rdy  = 1'b0;
                out_vld = 1'b1;
            end
            default: begin
                in_rdy  = 1'b1;
                out_vld = 1'b0;
            end
        endcase
    end

    // Entry datapath next values: main always holds the presented entry, skid the next one
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            main_d = ENTRY_RST;
            skid_d = ENTRY_RST;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d = in_entry;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_entry;
                    end else if (in_fire) begin
                        skid_d = in_entry;
                    end else if (out_fire) begin
                        main_d = ENTRY_RST;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        main_d = skid_q;
                        skid_d = ENTRY_RST;
                    end
                end
                default: begin
                    main_d = ENTRY_RST;
                    skid_d = ENTRY_RST;
                end
            endcase
        end
    end

    // Entry registers
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= ENTRY_RST;
            skid_q <= ENTRY_RST;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_ctrl  = main_q.ctrl;
    assign bus.out_data  = main_q.data;

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;

    // Saturating stall/bubble counters; flush does not clear them
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_vld && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (!out_vld && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = CNT_W'(0);
    assign bubble_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: scoreboard queue plus occupancy model
// checks handshake, ordering, bubbles, flush, reset and perf counters.
module tb_pipe_stage_reg;

    localparam int unsigned       DATA_W   = 64;
    localparam int unsigned       CTRL_W   = 16;
    localparam logic [CTRL_W-1:0] CTRL_RST = 16'hC3A0;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

    pipe_stage_reg #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .CTRL_RST(CTRL_RST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;
    int occ     = 0;
    bit model_ok = 1'b0;
    logic [CTRL_W+DATA_W-1:0] sb [$];

    function automatic logic [CTRL_W-1:0] ctrl_of(input logic [DATA_W-1:0] d);
        return CTRL_W'(d) ^ 16'h5A5A;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit ordy,
                         input bit fl, input bit r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_ctrl   = ctrl_of(d);
        bus.out_ready = ordy;
        flush         = fl;
        rst           = r;
    endtask

    // Check outputs against the model, take one clock edge, update the model
    task automatic cycle(input string tag);
        bit ein  = 1'b0;
        bit eout = 1'b0;
        bit ifire;
        bit ofire;
        logic [CTRL_W+DATA_W-1:0] front;
        if (model_ok) begin
            ein  = (occ != 2);
            eout = (occ != 0);
            check({tag, ".in_ready"}, 128'(bus.in_ready), 128'(ein));
            check({tag, ".out_valid"}, 128'(bus.out_valid), 128'(eout));
            if (eout) begin
                front = sb[0];
                check({tag, ".out_entry"}, 128'({bus.out_ctrl, bus.out_data}), 128'(front));
            end else begin
                check({tag, ".bubble"}, 128'({bus.out_ctrl, bus.out_data}),
                      128'({CTRL_RST, 64'd0}));
            end
        end
        @(posedge clk);
        if (rst) begin
            sb.delete();
            occ      = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            ifire = bus.in_valid && ein;
            ofire = eout && bus.out_ready;
            if (ofire) begin
                void'(sb.pop_front());
                occ--;
            end
            if (flush) begin
                sb.delete();
                occ = 0;
            end else if (ifire) begin
                sb.push_back({bus.in_ctrl, bus.in_data});
                occ++;
            end
        end
        #1;
    endtask

    initial begin
        // Reset for two cycles
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        cycle("rst0");
        cycle("rst1");

        // Stream 1..8 at full throughput
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 64'(i), 1'b1, 1'b0, 1'b0);
            cycle("stream");
        end
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        cycle("stream_drain");
        cycle("stream_idle");

        // Stall with skid fill, then release in order
        drive(1'b1, 64'd1, 1'b1, 1'b0, 1'b0);
        cycle("skid_in1");
        drive(1'b1, 64'd2, 1'b0, 1'b0, 1'b0);
        cycle("skid_in2");
        drive(1'b1, 64'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle("skid_hold");
        end
        drive(1'b1, 64'd3, 1'b1, 1'b0, 1'b0);
        cycle("skid_rel1");
        cycle("skid_rel2");
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        cycle("skid_rel3");
        cycle("skid_idle");

        // Flush in TWO with a new input pending and downstream stalled
        drive(1'b1, 64'd4, 1'b0, 1'b0, 1'b0);
        cycle("fl_in4");
        drive(1'b1, 64'd5, 1'b0, 1'b0, 1'b0);
        cycle("fl_in5");
        drive(1'b1, 64'd9, 1'b0, 1'b1, 1'b0);
        cycle("fl_two");
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        cycle("fl_after");
        cycle("fl_idle");

        // Flush in TWO while downstream accepts: main delivered, skid dropped
        drive(1'b1, 64'd10, 1'b0, 1'b0, 1'b0);
        cycle("fl2_in10");
        drive(1'b1, 64'd11, 1'b0, 1'b0, 1'b0);
        cycle("fl2_in11");
        drive(1'b1, 64'd12, 1'b1, 1'b1, 1'b0);
        cycle("fl2_two");
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        cycle("fl2_after");

        // Reset while holding A5
        drive(1'b1, 64'hA5, 1'b0, 1'b0, 1'b0);
        cycle("mr_inA5");
        drive(1'b1, 64'h66, 1'b1, 1'b0, 1'b1);
        cycle("mr_rst");
        drive(1'b1, 64'd7, 1'b1, 1'b0, 1'b0);
        cycle("mr_in7");
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        cycle("mr_out7");
        cycle("mr_idle");

        // Performance counters
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        cycle("perf_rst");
        check("perf_rst.stall", 128'(stall_cnt), 128'(32'd0));
        check("perf_rst.bubble", 128'(bubble_cnt), 128'(32'd0));
        drive(1'b1, 64'h21, 1'b0, 1'b0, 1'b0);
        cycle("perf_load");
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle("perf_stall");
        end
`ifdef PIPE_STAGE_PERF_EN
        check("perf_stall.stall", 128'(stall_cnt), 128'(32'd3));
        check("perf_stall.bubble", 128'(bubble_cnt), 128'(32'd1));
`else
        check("perf_stall.stall", 128'(stall_cnt), 128'(32'd0));
        check("perf_stall.bubble", 128'(bubble_cnt), 128'(32'd0));
`endif
        drive(1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
        cycle("perf_flush");
`ifdef PIPE_STAGE_PERF_EN
        check("perf_flush.stall", 128'(stall_cnt), 128'(32'd3));
        check("perf_flush.bubble", 128'(bubble_cnt), 128'(32'd1));
`else
        check("perf_flush.stall", 128'(stall_cnt), 128'(32'd0));
        check("perf_flush.bubble", 128'(bubble_cnt), 128'(32'd0));
`endif
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle("perf_idle");
        end
`ifdef PIPE_STAGE_PERF_EN
        check("perf_idle.stall", 128'(stall_cnt), 128'(32'd3));
        check("perf_idle.bubble", 128'(bubble_cnt), 128'(32'd4));
`else
        check("perf_idle.stall", 128'(stall_cnt), 128'(32'd0));
        check("perf_idle.bubble", 128'(bubble_cnt), 128'(32'd0));
`endif
        cycle("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
